// File: rtl/enigma_pkg.sv
// Shared defaults and width derivation for the QoS reorder buffer.
package enigma_pkg;

  localparam int ENIGMA_NPORT = 2;
  localparam int ENIGMA_DW    = 128;
  localparam int ENIGMA_IDW   = 5;
  localparam int ENIGMA_QW    = 2;
  localparam int ENIGMA_DEPTH = 4;

  // Port-index width; a single bit is kept even for two ports.
  function automatic int enigma_pw(input int nport);
    return (nport > 2) ? $clog2(nport) : 1;
  endfunction

  function automatic int enigma_ow(input int idw, input int nport);
    return idw + enigma_pw(nport);
  endfunction

endpackage

// File: rtl/enigma_fifo.sv
// Per-port FIFO; full/empty come from a registered occupancy count.
module enigma_fifo
  import enigma_pkg::*;
#(
  parameter int W     = ENIGMA_DW + ENIGMA_IDW + ENIGMA_QW,
  parameter int DEPTH = ENIGMA_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_wr;
  logic          do_rd;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/enigma_qos_buffer.sv
// Multi-port QoS buffer: per-port FIFOs, outstanding-id tracking and a
// priority/round-robin arbiter with stall lock and conflict back-off.
module enigma_qos_buffer
  import enigma_pkg::*;
#(
  parameter int NPORT = ENIGMA_NPORT,
  parameter int DW    = ENIGMA_DW,
  parameter int IDW   = ENIGMA_IDW,
  parameter int QW    = ENIGMA_QW,
  parameter int DEPTH = ENIGMA_DEPTH,
  localparam int PW   = enigma_pw(NPORT),
  localparam int OW   = enigma_ow(IDW, NPORT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NPORT*DW-1:0]  payload_i,
  input  logic [NPORT*IDW-1:0] id_i,
  input  logic [NPORT*QW-1:0]  qos_i,
  input  logic [NPORT-1:0]     valid_i,
  output logic [NPORT-1:0]     ready_i,
  output logic [DW-1:0]        payload_c,
  output logic [OW-1:0]        id_c,
  output logic [QW-1:0]        qos_c,
  output logic                 valid_c,
  input  logic                 ready_c,
  input  logic                 conflict_c,
  input  logic                 release_c,
  input  logic [OW-1:0]        releaseid_c
);

  localparam int EW  = DW + IDW + QW;
  localparam int NID = 1 << OW;

  logic [EW-1:0]    head     [NPORT];
  logic [DW-1:0]    head_pl  [NPORT];
  logic [QW-1:0]    head_qos [NPORT];
  logic [OW-1:0]    tag      [NPORT];
  logic [NPORT-1:0] empty, full, push, pop, elig;
  logic [NPORT-1:0] mask_q, mask_d;
  logic [NID-1:0]   bitmap_q, bitmap_d;
  logic [PW-1:0]    ptr_q, win, cand, lock_port_q;
  logic [QW-1:0]    best;
  logic             lock_q, found, xfer;

  // Ready is purely registered-full based, forced low while in reset.
  assign ready_i = rst ? '0 : ~full;
  assign push    = valid_i & ready_i;

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    enigma_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (push[p]),
      .wr_data ({payload_i[p*DW +: DW], id_i[p*IDW +: IDW], qos_i[p*QW +: QW]}),
      .rd_en   (pop[p]),
      .rd_data (head[p]),
      .empty   (empty[p]),
      .full    (full[p])
    );
    assign head_pl[p]  = head[p][EW-1 -: DW];
    assign head_qos[p] = head[p][QW-1:0];
    assign tag[p]      = {PW'(p), head[p][QW +: IDW]};
    assign elig[p]     = ~empty[p] & ~mask_q[p] & ~bitmap_q[tag[p]];
  end

  // Scan from the pointer; strict '>' keeps the earliest port on qos ties.
  always_comb begin
    found = 1'b0;
    win   = '0;
    best  = '0;
    cand  = '0;
    for (int k = 0; k < NPORT; k++) begin
      cand = (int'(ptr_q) + k >= NPORT) ? PW'(int'(ptr_q) + k - NPORT)
                                         : PW'(int'(ptr_q) + k);
      if (elig[cand] && (!found || head_qos[cand] > best)) begin
        found = 1'b1;
        win   = cand;
        best  = head_qos[cand];
      end
    end
    if (lock_q) begin
      found = 1'b1;
      win   = lock_port_q;
    end
    if (rst) found = 1'b0;
  end

  assign valid_c   = found;
  assign payload_c = found ? head_pl[win]  : '0;
  assign id_c      = found ? tag[win]      : '0;
  assign qos_c     = found ? head_qos[win] : '0;
  assign xfer      = found & ready_c & ~conflict_c;

  always_comb begin
    pop    = '0;
    mask_d = '0;
    if (xfer)               pop[win]    = 1'b1;
    if (found & conflict_c) mask_d[win] = 1'b1;
  end

  // Release is applied first so a same-cycle set on the same id wins.
  always_comb begin
    bitmap_d = bitmap_q;
    if (release_c) bitmap_d[releaseid_c] = 1'b0;
    if (xfer)      bitmap_d[tag[win]]    = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bitmap_q    <= '0;
      ptr_q       <= '0;
      mask_q      <= '0;
      lock_q      <= 1'b0;
      lock_port_q <= '0;
    end else begin
      bitmap_q    <= bitmap_d;
      mask_q      <= mask_d;
      lock_q      <= found & ~ready_c & ~conflict_c;
      lock_port_q <= win;
      if (xfer) ptr_q <= (win == PW'(NPORT-1)) ? '0 : win + PW'(1);
    end
  end

endmodule

// File: tb/tb_enigma_qos_buffer.sv
// Directed bench for enigma_qos_buffer at default parameters.
module tb_enigma_qos_buffer;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] payload_i;
  logic [9:0]   id_i;
  logic [3:0]   qos_i;
  logic [1:0]   valid_i;
  logic [1:0]   ready_i;
  logic [127:0] payload_c;
  logic [5:0]   id_c;
  logic [1:0]   qos_c;
  logic         valid_c;
  logic         ready_c;
  logic         conflict_c;
  logic         release_c;
  logic [5:0]   releaseid_c;

  int checks = 0;
  int errors = 0;

  enigma_qos_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .payload_i   (payload_i),
    .id_i        (id_i),
    .qos_i       (qos_i),
    .valid_i     (valid_i),
    .ready_i     (ready_i),
    .payload_c   (payload_c),
    .id_c        (id_c),
    .qos_c       (qos_c),
    .valid_c     (valid_c),
    .ready_c     (ready_c),
    .conflict_c  (conflict_c),
    .release_c   (release_c),
    .releaseid_c (releaseid_c)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input int p, input logic v, input logic [4:0] id,
                     input logic [1:0] q, input logic [127:0] pl);
    valid_i[p]          = v;
    id_i[p*5 +: 5]      = id;
    qos_i[p*2 +: 2]     = q;
    payload_i[p*128 +: 128] = pl;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic beat(input string tag, input logic [5:0] id, input logic [1:0] q,
                      input logic [127:0] pl);
    chk({tag, "_valid"}, 128'(valid_c), 128'(1));
    chk({tag, "_id"}, 128'(id_c), 128'(id));
    chk({tag, "_qos"}, 128'(qos_c), 128'(q));
    chk({tag, "_payload"}, payload_c, pl);
  endtask

  initial begin
    rst = 1'b1; payload_i = '0; id_i = '0; qos_i = '0; valid_i = '0;
    ready_c = 1'b0; conflict_c = 1'b0; release_c = 1'b0; releaseid_c = '0;
    cyc(); cyc();
    chk("rst_valid", 128'(valid_c), 128'(0));
    chk("rst_ready", 128'(ready_i), 128'(0));
    chk("rst_id", 128'(id_c), 128'(0));
    chk("rst_payload", payload_c, 128'(0));
    rst = 1'b0;
    cyc();
    chk("post_rst_ready", 128'(ready_i), 128'(3));
    chk("post_rst_valid", 128'(valid_c), 128'(0));

    // qos priority: B (qos 2) before A (qos 1)
    drv(0, 1'b1, 5'd3, 2'd1, 128'hAAAA);
    drv(1, 1'b1, 5'd3, 2'd2, 128'hBBBB);
    ready_c = 1'b1;
    cyc();
    drv(0, 1'b0, 5'd0, 2'd0, 128'h0);
    drv(1, 1'b0, 5'd0, 2'd0, 128'h0);
    beat("qos_first", 6'h23, 2'd2, 128'hBBBB);
    cyc();
    beat("qos_second", 6'h03, 2'd1, 128'hAAAA);
    cyc();
    chk("qos_drained", 128'(valid_c), 128'(0));
    chk("idle_payload_zero", payload_c, 128'(0));
    release_c = 1'b1; releaseid_c = 6'h23;
    cyc();
    releaseid_c = 6'h03;
    cyc();
    release_c = 1'b0;

    // outstanding id blocks a repeat until released
    drv(0, 1'b1, 5'd7, 2'd0, 128'h71);
    cyc();
    beat("dup_first", 6'h07, 2'd0, 128'h71);
    drv(0, 1'b1, 5'd7, 2'd0, 128'h72);
    cyc();
    drv(0, 1'b0, 5'd0, 2'd0, 128'h0);
    chk("dup_blocked", 128'(valid_c), 128'(0));
    cyc();
    chk("dup_still_blocked", 128'(valid_c), 128'(0));
    release_c = 1'b1; releaseid_c = 6'h07;
    cyc();
    beat("dup_released", 6'h07, 2'd0, 128'h72);
    // release stays high: same-cycle set on 0x07 must win
    cyc();
    release_c = 1'b0;
    drv(0, 1'b1, 5'd7, 2'd0, 128'h73);
    cyc();
    drv(0, 1'b0, 5'd0, 2'd0, 128'h0);
    chk("set_wins_blocked", 128'(valid_c), 128'(0));
    release_c = 1'b1; releaseid_c = 6'h07;
    cyc();
    release_c = 1'b0;
    beat("set_wins_released", 6'h07, 2'd0, 128'h73);
    cyc();
    chk("set_wins_drained", 128'(valid_c), 128'(0));
    release_c = 1'b1; releaseid_c = 6'h07;
    cyc();
    release_c = 1'b0;

    // stall lock: A held for 5 cycles although B has higher qos
    ready_c = 1'b0;
    drv(0, 1'b1, 5'd1, 2'd0, 128'hA1);
    cyc();
    drv(0, 1'b0, 5'd0, 2'd0, 128'h0);
    beat("lock_offer", 6'h01, 2'd0, 128'hA1);
    drv(1, 1'b1, 5'd2, 2'd3, 128'hB2);
    cyc();
    drv(1, 1'b0, 5'd0, 2'd0, 128'h0);
    for (int i = 0; i < 5; i++) begin
      beat($sformatf("lock_hold%0d", i), 6'h01, 2'd0, 128'hA1);
      if (i < 4) cyc();
    end
    ready_c = 1'b1;
    cyc();
    beat("lock_after", 6'h22, 2'd3, 128'hB2);
    cyc();
    chk("lock_drained", 128'(valid_c), 128'(0));
    release_c = 1'b1; releaseid_c = 6'h01;
    cyc();
    releaseid_c = 6'h22;
    cyc();
    release_c = 1'b0;

    // conflict masks A for one cycle, B goes first, A follows
    drv(0, 1'b1, 5'd4, 2'd2, 128'hA4);
    drv(1, 1'b1, 5'd5, 2'd1, 128'hB5);
    cyc();
    drv(0, 1'b0, 5'd0, 2'd0, 128'h0);
    drv(1, 1'b0, 5'd0, 2'd0, 128'h0);
    beat("cfl_offer", 6'h04, 2'd2, 128'hA4);
    conflict_c = 1'b1;
    cyc();
    conflict_c = 1'b0;
    beat("cfl_other", 6'h25, 2'd1, 128'hB5);
    cyc();
    beat("cfl_retry", 6'h04, 2'd2, 128'hA4);
    cyc();
    chk("cfl_drained", 128'(valid_c), 128'(0));

    // fill port 0 with ready_c low
    ready_c = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drv(0, 1'b1, 5'(10 + i), 2'd0, 128'(16'hD0 + i));
      if (i == 3) chk("fill_ready_3", 128'(ready_i), 128'(3));
      if (i == 4) chk("fill_ready_full", 128'(ready_i), 128'(2));
      cyc();
    end
    drv(0, 1'b0, 5'd0, 2'd0, 128'h0);
    chk("full_ready_hold", 128'(ready_i), 128'(2));
    beat("full_head", 6'h0A, 2'd0, 128'hD0);
    ready_c = 1'b1;
    cyc();
    chk("pop_ready_back", 128'(ready_i), 128'(3));
    beat("pop_next_head", 6'h0B, 2'd0, 128'hD1);

    // reset mid-traffic discards FIFOs, bitmap and pointer
    rst = 1'b1; ready_c = 1'b0;
    cyc();
    chk("mid_rst_valid", 128'(valid_c), 128'(0));
    chk("mid_rst_ready", 128'(ready_i), 128'(0));
    chk("mid_rst_id", 128'(id_c), 128'(0));
    rst = 1'b0;
    cyc();
    chk("mid_rst_after_ready", 128'(ready_i), 128'(3));
    chk("mid_rst_after_valid", 128'(valid_c), 128'(0));
    drv(0, 1'b1, 5'd10, 2'd1, 128'hC0);
    drv(1, 1'b1, 5'd11, 2'd1, 128'hC1);
    ready_c = 1'b1;
    cyc();
    drv(0, 1'b0, 5'd0, 2'd0, 128'h0);
    drv(1, 1'b0, 5'd0, 2'd0, 128'h0);
    beat("rst_ptr_tie_p0", 6'h0A, 2'd1, 128'hC0);
    cyc();
    beat("rst_ptr_tie_p1", 6'h2B, 2'd1, 128'hC1);
    cyc();
    chk("final_idle", 128'(valid_c), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
